// File: rtl/puf_output_network_mv_if.sv
// Handshake bundle between the PUF capture register, the voting network and the serialiser.
// Both sides: a transfer happens on a rising clk edge where valid and ready are both high;
// valid, once raised, holds its payload stable until that transfer; ready never depends on valid.
interface puf_output_network_mv_if #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_data;
  logic [N_OUT-1:0] out_stable;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_stable
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_stable
  );
endinterface

// File: rtl/puf_output_network_mv.sv
// Windowed shifted XOR network over raw PUF responses, majority-voted across VOTES
// evaluations, with a per-bit stability mask. dbg_hold_o exposes the FSM state (1 = HOLD).
module puf_output_network_mv #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 9,
  parameter int WIN   = 2,
  parameter int SHIFT = 1,
  parameter int VOTES = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  puf_output_network_mv_if.slave    bus,
  output logic                      dbg_hold_o
);
  localparam int CNT_W = $clog2(VOTES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VOTES - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(VOTES / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(VOTES);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] smp_q;
  logic [CNT_W-1:0] ones_q [N_OUT];
  logic [CNT_W-1:0] ones_d [N_OUT];
  logic [N_OUT-1:0] net;
  logic [N_OUT-1:0] out_data_q, out_data_d;
  logic [N_OUT-1:0] out_stable_q, out_stable_d;

  // Window of output idx, wrapping modulo N_IN; overlapping wrapped taps still XOR once each.
  function automatic logic [N_IN-1:0] win_mask(input int idx);
    logic [N_IN-1:0] m;
    m = '0;
    for (int j = 0; j < WIN; j++) begin
      m = m | (N_IN'(1) << ((idx * SHIFT + j) % N_IN));
    end
    return m;
  endfunction

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_net
    localparam logic [N_IN-1:0] MASK = win_mask(gi);
    assign net[gi] = ^(bus.in_data & MASK);
  end

  // Vote totals including the sample on the bus; only committed when it is accepted.
  always_comb begin
    out_data_d   = '0;
    out_stable_d = '0;
    for (int i = 0; i < N_OUT; i++) begin
      ones_d[i]       = ones_q[i] + CNT_W'(net[i]);
      out_data_d[i]   = (ones_d[i] > HALF);
      out_stable_d[i] = (ones_d[i] == '0) | (ones_d[i] == FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_COLLECT;
      smp_q        <= '0;
      out_data_q   <= '0;
      out_stable_q <= '0;
      for (int i = 0; i < N_OUT; i++) ones_q[i] <= '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N_OUT; i++) ones_q[i] <= ones_d[i];
            smp_q <= smp_q + CNT_W'(1);
            if (smp_q == LAST) begin
              state_q      <= S_HOLD;
              out_data_q   <= out_data_d;
              out_stable_q <= out_stable_d;
            end
          end
        end
        S_HOLD: begin
          // Counters are cleared here, so a new vote starts from zero next cycle.
          if (bus.out_ready) begin
            state_q <= S_COLLECT;
            smp_q   <= '0;
            for (int i = 0; i < N_OUT; i++) ones_q[i] <= '0;
          end
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == S_COLLECT);
  assign bus.out_valid  = (state_q == S_HOLD);
  assign bus.out_data   = out_data_q;
  assign bus.out_stable = out_stable_q;
  assign dbg_hold_o     = (state_q == S_HOLD);
endmodule

// File: tb/tb_puf_output_network_mv.sv
// Bench for puf_output_network_mv: default instance plus a VOTES=1, WIN=3 instance,
// directed vectors with hand-computed results checked by per-instance scoreboards.
module tb_puf_output_network_mv;
  // clock / reset
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  puf_output_network_mv_if #(.N_IN(10), .N_OUT(9)) bus_a ();
  puf_output_network_mv_if #(.N_IN(10), .N_OUT(9)) bus_b ();
  logic dbg_a, dbg_b;

  puf_output_network_mv dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_a.slave),
    .dbg_hold_o (dbg_a)
  );

  puf_output_network_mv #(.N_IN(10), .N_OUT(9), .WIN(3), .SHIFT(1), .VOTES(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_b.slave),
    .dbg_hold_o (dbg_b)
  );

  // scoreboard: {out_data, out_stable}
  logic [17:0] exp_a_q[$];
  logic [17:0] exp_b_q[$];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [9:0] PAT = 10'b0101010110;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_a.out_valid && bus_a.out_ready) begin
      if (exp_a_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_result: got %0h/%0h with nothing expected", bus_a.out_data, bus_a.out_stable);
      end else begin
        logic [17:0] e;
        e = exp_a_q.pop_front();
        chk("a_out_data", bus_a.out_data, e[17:9]);
        chk("a_out_stable", bus_a.out_stable, e[8:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_b.out_valid && bus_b.out_ready) begin
      if (exp_b_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_result: got %0h/%0h with nothing expected", bus_b.out_data, bus_b.out_stable);
      end else begin
        logic [17:0] e;
        e = exp_b_q.pop_front();
        chk("b_out_data", bus_b.out_data, e[17:9]);
        chk("b_out_stable", bus_b.out_stable, e[8:0]);
      end
    end
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_a(input logic [9:0] d);
    int cnt;
    cnt = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    while (!bus_a.in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    if (cnt >= 50) chk("a_in_ready_timeout", bus_a.in_ready, 1);
    tick();
    bus_a.in_valid = 1'b0;
  endtask

  initial begin
    logic [9:0]  b_in  [4];
    logic [17:0] b_exp [4];
    int start, gaps, g;

    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_in_ready", bus_a.in_ready, 1);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_data", bus_a.out_data, 0);
    chk("rst_out_stable", bus_a.out_stable, 0);
    chk("rst_state", dbg_a, 0);
    chk("rst_b_out_valid", bus_b.out_valid, 0);

    // all-identical samples, gap-free, consumer always ready
    bus_a.out_ready = 1'b1;
    exp_a_q.push_back({9'h1FD, 9'h1FF});
    start = cyc;
    repeat (4) send_a(PAT);
    chk("t1_no_early_valid", bus_a.out_valid, 0);
    send_a(PAT);
    chk("t1_out_valid", bus_a.out_valid, 1);
    chk("t1_latency", cyc - start, 5);
    chk("t1_in_ready_low", bus_a.in_ready, 0);
    tick();
    chk("t1_in_ready_after", bus_a.in_ready, 1);
    chk("t1_valid_dropped", bus_a.out_valid, 0);

    // mixed samples: bit 1 always zero, others 3 of 5
    exp_a_q.push_back({9'h1FD, 9'h002});
    repeat (3) send_a(PAT);
    repeat (2) send_a(10'h000);
    chk("t2_out_valid", bus_a.out_valid, 1);
    tick();

    // backpressure with a sample waiting on the input
    bus_a.out_ready = 1'b0;
    exp_a_q.push_back({9'h001, 9'h1FF});
    repeat (5) send_a(10'h001);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = PAT;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_in_ready", bus_a.in_ready, 0);
      chk("t3_out_valid", bus_a.out_valid, 1);
      chk("t3_data_hold", bus_a.out_data, 9'h001);
      chk("t3_stable_hold", bus_a.out_stable, 9'h1FF);
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    chk("t3_collect_after", bus_a.in_ready, 1);
    chk("t3_valid_after", bus_a.out_valid, 0);
    exp_a_q.push_back({9'h1FD, 9'h1FF});
    repeat (5) send_a(PAT);
    chk("t3_next_valid", bus_a.out_valid, 1);
    bus_a.out_ready = 1'b1;
    tick();

    // reset mid-collection discards the partial vote
    repeat (3) send_a(PAT);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_in_ready", bus_a.in_ready, 1);
    chk("t4_out_valid", bus_a.out_valid, 0);
    chk("t4_out_data", bus_a.out_data, 0);
    chk("t4_out_stable", bus_a.out_stable, 0);
    exp_a_q.push_back({9'h001, 9'h1FF});
    repeat (4) send_a(10'h001);
    chk("t4_no_early_valid", bus_a.out_valid, 0);
    send_a(10'h001);
    chk("t4_out_valid", bus_a.out_valid, 1);
    tick();

    // idle gaps with junk on in_data only delay the result
    exp_a_q.push_back({9'h1FD, 9'h1FF});
    start = cyc;
    gaps  = 0;
    for (int k = 0; k < 5; k++) begin
      g = (k == 0) ? 1 : int'($urandom_range(0, 1));
      gaps += g;
      bus_a.in_valid = 1'b0;
      bus_a.in_data  = 10'($urandom);
      repeat (g) tick();
      send_a(PAT);
    end
    chk("t5_out_valid", bus_a.out_valid, 1);
    chk("t5_latency", cyc - start, 5 + gaps);
    tick();

    // VOTES=1, WIN=3 instance: one sample per result, windows wrap past in[9]
    b_in[0] = 10'b1000000001; b_exp[0] = {9'h081, 9'h1FF};
    b_in[1] = 10'b0000000011; b_exp[1] = {9'h102, 9'h1FF};
    b_in[2] = 10'b1100000000; b_exp[2] = {9'h040, 9'h1FF};
    b_in[3] = 10'h3FF;        b_exp[3] = {9'h1FF, 9'h1FF};
    bus_b.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b_q.push_back(b_exp[k]);
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = b_in[k];
      tick();
      bus_b.in_valid = 1'b0;
      chk("b_out_valid", bus_b.out_valid, 1);
      chk("b_in_ready_low", bus_b.in_ready, 0);
      tick();
      chk("b_in_ready_after", bus_b.in_ready, 1);
    end

    // final report
    repeat (3) tick();
    chk("a_results_missing", exp_a_q.size(), 0);
    chk("b_results_missing", exp_b_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
